// File: rtl/cordic_sched_if.sv
// Requester/response bundle between the angle generators and the trig scheduler.
interface cordic_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned AW   = 25,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]      req_vld;
  logic [NREQ*AW-1:0]   req_angle;
  logic [NREQ-1:0]      req_rdy;
  logic                 rsp_vld;
  logic [IDW-1:0]       rsp_id;
  logic signed [DW-1:0] rsp_sin;
  logic signed [DW-1:0] rsp_cos;

  // Angle generators / result consumers
  modport master (
    output req_vld, req_angle,
    input  req_rdy, rsp_vld, rsp_id, rsp_sin, rsp_cos
  );

  // Scheduler
  modport slave (
    input  req_vld, req_angle,
    output req_rdy, rsp_vld, rsp_id, rsp_sin, rsp_cos
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined first-quadrant CORDIC among
// NREQ requesters; folds full-circle angles and restores signs on return.
module cordic_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 18,
  parameter int unsigned AW   = 25,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  cordic_sched_if.slave        bus,
  output logic [AW-1:0]        cordic_angle,
  output logic                 cordic_vld,
  input  logic signed [DW-1:0] cordic_sin,
  input  logic signed [DW-1:0] cordic_cos,
  output logic [4:0]           inflight
);
  localparam int unsigned DEG = 65536;
  localparam logic [AW-1:0] A90  = AW'(90 * DEG);
  localparam logic [AW-1:0] A180 = AW'(180 * DEG);
  localparam logic [AW-1:0] A270 = AW'(270 * DEG);
  localparam logic [AW-1:0] A360 = AW'(360 * DEG);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           sneg;
    logic           cneg;
  } sb_t;

  logic [IDW-1:0] ptr;
  logic           gnt_any_c;
  logic [IDW-1:0] gnt_id_c;
  logic [IDW-1:0] idx_c;
  logic [AW-1:0]  ang_c;
  logic [AW-1:0]  wrap_c;
  logic [AW-1:0]  fold_c;
  logic           sneg_c;
  logic           cneg_c;
  sb_t            iss;
  sb_t            sb [LAT];
  sb_t            sb_out;

  assign sb_out     = sb[LAT-1];
  assign cordic_vld = iss.vld;

  // Round-robin pick: first valid requester at or after ptr, blocked by en/reset
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    idx_c     = '0;
    if (en && rst_n) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx_c = IDW'((32'(ptr) + k) % NREQ);
        if (!gnt_any_c && bus.req_vld[idx_c]) begin
          gnt_any_c = 1'b1;
          gnt_id_c  = idx_c;
        end
      end
    end
  end

  assign bus.req_rdy = gnt_any_c ? (NREQ'(1) << gnt_id_c) : '0;

  // Fold the granted angle into 0..90 deg and record which signs to restore
  always_comb begin
    ang_c  = bus.req_angle[32'(gnt_id_c) * AW +: AW];
    wrap_c = (ang_c >= A360) ? ang_c - A360 : ang_c;
    fold_c = wrap_c;
    sneg_c = 1'b0;
    cneg_c = 1'b0;
    if (wrap_c > A270) begin
      fold_c = A360 - wrap_c;
      sneg_c = 1'b1;
    end else if (wrap_c > A180) begin
      fold_c = wrap_c - A180;
      sneg_c = 1'b1;
      cneg_c = 1'b1;
    end else if (wrap_c > A90) begin
      fold_c = A180 - wrap_c;
      cneg_c = 1'b1;
    end
  end

  // Issue stage: engine angle, sideband entry and pointer advance on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cordic_angle <= '0;
      iss          <= '0;
      ptr          <= '0;
    end else begin
      iss.vld <= 1'b0;
      if (gnt_any_c) begin
        cordic_angle <= fold_c;
        iss          <= '{vld: 1'b1, id: gnt_id_c, sneg: sneg_c, cneg: cneg_c};
        ptr          <= (32'(gnt_id_c) == NREQ - 1) ? '0 : gnt_id_c + 1'b1;
      end
    end
  end

  // Sideband delay line tracking the engine so its tail meets cordic_sin/cos
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) sb[k] <= '0;
    end else begin
      sb[0] <= iss;
      for (int unsigned k = 1; k < LAT; k++) sb[k] <= sb[k-1];
    end
  end

  // Sign-corrected, ID-tagged response; data holds when nothing returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_vld <= 1'b0;
      bus.rsp_id  <= '0;
      bus.rsp_sin <= '0;
      bus.rsp_cos <= '0;
    end else begin
      bus.rsp_vld <= sb_out.vld;
      if (sb_out.vld) begin
        bus.rsp_id  <= sb_out.id;
        bus.rsp_sin <= sb_out.sneg ? -cordic_sin : cordic_sin;
        bus.rsp_cos <= sb_out.cneg ? -cordic_cos : cordic_cos;
      end
    end
  end

  // Outstanding count: up on grant, down as a result leaves the sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({gnt_any_c, sb_out.vld})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench: ideal trig engine model plus a queue-based reference
// built from true sin/cos of the unfolded requester angle.
module tb_cordic_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned LAT  = 18;
  localparam int unsigned AW   = 25;
  localparam int unsigned DW   = 32;
  localparam int unsigned Q90  = 90 * 65536;
  localparam real         PI   = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [AW-1:0]        cordic_angle;
  logic                 cordic_vld;
  logic signed [DW-1:0] cordic_sin;
  logic signed [DW-1:0] cordic_cos;
  logic [4:0]           inflight;

  cordic_sched_if #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) bus ();

  cordic_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bus          (bus),
    .cordic_angle (cordic_angle),
    .cordic_vld   (cordic_vld),
    .cordic_sin   (cordic_sin),
    .cordic_cos   (cordic_cos),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  function automatic int qround(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int trig(input int unsigned a, input bit want_sin);
    real r;
    r = real'(a) / 65536.0 * PI / 180.0;
    return qround(want_sin ? $sin(r) * 65536.0 : $cos(r) * 65536.0);
  endfunction

  // Fold rule: bring the angle into the first quadrant
  function automatic int unsigned fold(input int unsigned a_in);
    int unsigned a;
    a = (a_in >= 4 * Q90) ? a_in - 4 * Q90 : a_in;
    if (a <= Q90)     return a;
    if (a <= 2 * Q90) return 2 * Q90 - a;
    if (a <= 3 * Q90) return a - 2 * Q90;
    return 4 * Q90 - a;
  endfunction

  // Ideal engine: result appears LAT edges after cordic_angle changes
  int eng_s [LAT];
  int eng_c [LAT];
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      eng_s[k] <= eng_s[k-1];
      eng_c[k] <= eng_c[k-1];
    end
    eng_s[0] <= trig(32'(cordic_angle), 1'b1);
    eng_c[0] <= trig(32'(cordic_angle), 1'b0);
  end
  assign cordic_sin = eng_s[LAT-1];
  assign cordic_cos = eng_c[LAT-1];

  typedef struct {
    int unsigned id;
    int          s;
    int          c;
    int          due;
  } exp_t;

  exp_t            q[$];
  logic [NREQ-1:0] gq[$];
  int unsigned     ptr_m;
  int              cyc;
  int              n_pass;
  int              n_chk;
  int              n_rsp;
  int              n_gnt;
  int              peak;
  logic [NREQ-1:0] vld_d;
  int unsigned     ang_d [NREQ];
  bit              hold_mode;
  int              last_rsp_cyc;
  int unsigned     last_rsp_id;
  int              last_rsp_s;
  int              last_rsp_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic chk_near(input string tag, input logic signed [DW-1:0] obs, input int exp);
    int d;
    n_chk++;
    d = int'(obs) - exp;
    if (d < 0) d = -d;
    assert (!$isunknown(obs) && d <= 16) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d +-16", tag, obs, exp);
  endtask

  task automatic apply();
    bus.req_vld = vld_d;
    for (int i = 0; i < NREQ; i++) bus.req_angle[i*AW +: AW] = AW'(ang_d[i]);
  endtask

  // One clock: predict grant, advance, then check issue/response/inflight
  task automatic cycle();
    logic [NREQ-1:0] exp_g;
    int unsigned     gid;
    int unsigned     idx;
    int unsigned     f_exp;
    bit              g;
    apply();
    #1;
    g = 1'b0;
    gid = 0;
    f_exp = 0;
    exp_g = '0;
    if (en && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + 32'(k)) % NREQ;
        if (!g && vld_d[idx]) begin
          g = 1'b1;
          gid = idx;
        end
      end
    end
    if (g) exp_g[gid] = 1'b1;
    chk("req_rdy", 64'(bus.req_rdy), 64'(exp_g));
    if (bus.req_rdy != '0) gq.push_back(bus.req_rdy);
    @(posedge clk);
    cyc++;
    if (g) begin
      q.push_back('{id: gid, s: trig(ang_d[gid], 1'b1), c: trig(ang_d[gid], 1'b0),
                    due: cyc + int'(LAT) + 1});
      f_exp = fold(ang_d[gid]);
      ptr_m = (gid + 1) % NREQ;
      n_gnt++;
      if (hold_mode) ang_d[gid] = $urandom_range(33554431);
      else vld_d[gid] = 1'b0;
    end
    @(negedge clk);
    chk("cordic_vld", 64'(cordic_vld), 64'(g));
    if (g) chk("cordic_angle", 64'(cordic_angle), 64'(f_exp));
    if (bus.rsp_vld === 1'b1) n_rsp++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_vld", 64'(bus.rsp_vld), 64'(1));
      chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
      chk_near("rsp_sin", bus.rsp_sin, q[0].s);
      chk_near("rsp_cos", bus.rsp_cos, q[0].c);
      last_rsp_cyc = cyc;
      last_rsp_id  = 32'(bus.rsp_id);
      last_rsp_s   = int'(bus.rsp_sin);
      last_rsp_c   = int'(bus.rsp_cos);
      void'(q.pop_front());
    end else begin
      chk("rsp_vld_idle", 64'(bus.rsp_vld), 64'(0));
    end
    chk("inflight", 64'(inflight), 64'(q.size()));
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  // Single request on an otherwise idle scheduler, checked against constants
  task automatic one(input int unsigned id, input int unsigned a, input int unsigned f_exp,
                     input int s_exp, input int c_exp);
    int gc;
    hold_mode = 1'b0;
    vld_d[id] = 1'b1;
    ang_d[id] = a;
    cycle();
    gc = cyc;
    chk("fold_const", 64'(cordic_angle), 64'(f_exp));
    repeat (LAT + 2) cycle();
    chk("latency", 64'(last_rsp_cyc - gc), 64'(LAT + 1));
    chk("rsp_id_const", 64'(last_rsp_id), 64'(id));
    chk_near("sin_const", DW'(last_rsp_s), s_exp);
    chk_near("cos_const", DW'(last_rsp_c), c_exp);
  endtask

  task automatic reset_values();
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
    chk("rst_cordic_angle", 64'(cordic_angle), 64'(0));
    chk("rst_cordic_vld", 64'(cordic_vld), 64'(0));
    chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_rsp_sin", 64'(bus.rsp_sin), 64'(0));
    chk("rst_rsp_cos", 64'(bus.rsp_cos), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
  endtask

  initial begin
    int base;
    int unsigned p0;
    n_pass = 0; n_chk = 0; n_rsp = 0; n_gnt = 0; cyc = 0; ptr_m = 0; peak = 0;
    vld_d = '0;
    hold_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) ang_d[i] = 0;
    apply();
    repeat (3) @(negedge clk);
    #1;
    reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Single angles across all quadrants and boundaries
    one(0, 1966080,  1966080,  32768,  56756);
    one(1, 9830400,  1966080,  32768, -56756);
    one(2, 13762560, 1966080, -32768, -56756);
    one(3, 21626880, 1966080, -32768,  56756);
    one(0, 0,        0,            0,  65536);
    one(1, 5898240,  5898240,  65536,      0);
    one(2, 26214400, 2621440,  42125,  50203);
    one(3, 23592960, 0,            0,  65536);
    one(0, 17694720, 5898240, -65536,      0);
    one(1, 33554431, 1835009,  30767, -57865);

    // 12-cycle burst from all requesters: strict rotation, peak 12
    p0 = ptr_m;
    gq.delete();
    peak = 0;
    base = n_rsp;
    hold_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) ang_d[i] = $urandom_range(33554431);
    vld_d = '1;
    repeat (12) cycle();
    vld_d = '0;
    repeat (LAT + 6) cycle();
    chk("burst_grants", 64'(gq.size()), 64'(12));
    for (int k = 0; k < 12 && k < gq.size(); k++)
      chk("rr_order", 64'(gq[k]), 64'(1) << ((p0 + 32'(k)) % NREQ));
    chk("burst_rsp", 64'(n_rsp - base), 64'(12));
    chk("burst_peak", 64'(peak), 64'(12));
    chk("burst_drain", 64'(inflight), 64'(0));

    // Held requests long enough to fill the pipe: peak LAT+1
    peak = 0;
    vld_d = '1;
    repeat (40) cycle();
    vld_d = '0;
    repeat (LAT + 4) cycle();
    chk("held_peak", 64'(peak), 64'(LAT + 1));
    chk("held_drain", 64'(inflight), 64'(0));

    // Randomized traffic with random en, holds and legal withdrawals
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld_d[i] && $urandom_range(1) == 1) begin
          vld_d[i] = 1'b1;
          ang_d[i] = $urandom_range(33554431);
        end else if (vld_d[i] && $urandom_range(15) == 0) begin
          vld_d[i] = 1'b0;
        end
      end
      en = ($urandom_range(7) != 0);
      hold_mode = ($urandom_range(1) == 1);
      cycle();
    end
    en = 1'b1;
    vld_d = '0;
    repeat (LAT + 4) cycle();
    chk("random_drain", 64'(inflight), 64'(0));

    // en low blocks grants; exactly five issues then drain
    en = 1'b0;
    hold_mode = 1'b1;
    vld_d = '1;
    repeat (5) cycle();
    chk("en0_rdy", 64'(bus.req_rdy), 64'(0));
    chk("en0_vld", 64'(cordic_vld), 64'(0));
    base = n_rsp;
    en = 1'b1;
    repeat (5) cycle();
    en = 1'b0;
    repeat (LAT + 6) cycle();
    chk("en_rsp_count", 64'(n_rsp - base), 64'(5));
    chk("en_drain", 64'(inflight), 64'(0));

    // Reset mid-flight discards everything outstanding
    en = 1'b1;
    vld_d = '1;
    repeat (8) cycle();
    en = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    q.delete();
    ptr_m = 0;
    #1;
    reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    vld_d = '1;
    apply();
    #1;
    chk("first_after_rst", 64'(bus.req_rdy), 64'(1));
    base = n_rsp;
    cycle();
    vld_d = '0;
    repeat (LAT + 6) cycle();
    chk("rst_rsp_count", 64'(n_rsp - base), 64'(1));
    chk("rst_drain", 64'(inflight), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
